// File: rtl/membus_pkg.sv
// Shared membus types for the two-master arbiter: widths, request bundle and owner tag.
package membus_pkg;

    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEMBUS_WMASK_W = MEM_DATA_WIDTH / 8;

    typedef logic [MEM_ADDR_WIDTH-1:0] Addr;
    typedef logic [MEM_DATA_WIDTH-1:0] Data;
    typedef logic [MEMBUS_WMASK_W-1:0] WMask;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } Owner;

    typedef struct packed {
        Addr  addr;
        logic wen;
        Data  wdata;
        WMask wmask;
    } MembusReq;

    function automatic Owner other_owner(input Owner o);
        return (o == OWNER_D) ? OWNER_I : OWNER_D;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// One-bit-wide FIFO holding the owner of each accepted membus request until its response.
// Full is derived from the registered count only, so a pop never frees a slot in the same cycle.
module owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[head_q];

    always_comb begin
        head_d  = do_pop  ? ptr_inc(head_q) : head_q;
        tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= din_i;
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// Two-master (instruction fetch / data) to one-slave membus arbiter with in-order response routing.
// Define MEMBUS_ARB_RR_EN for round-robin arbitration; default build uses fixed D-over-I priority.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    // instruction-fetch master
    input  logic                      i_membus_valid_i,
    output logic                      i_membus_ready_o,
    input  logic [MEM_ADDR_WIDTH-1:0] i_membus_addr_i,
    input  logic                      i_membus_wen_i,
    input  logic [MEM_DATA_WIDTH-1:0] i_membus_wdata_i,
    input  logic [MEMBUS_WMASK_W-1:0] i_membus_wmask_i,
    output logic                      i_membus_rvalid_o,
    output logic [MEM_DATA_WIDTH-1:0] i_membus_rdata_o,
    // data memory unit master
    input  logic                      d_membus_valid_i,
    output logic                      d_membus_ready_o,
    input  logic [MEM_ADDR_WIDTH-1:0] d_membus_addr_i,
    input  logic                      d_membus_wen_i,
    input  logic [MEM_DATA_WIDTH-1:0] d_membus_wdata_i,
    input  logic [MEMBUS_WMASK_W-1:0] d_membus_wmask_i,
    output logic                      d_membus_rvalid_o,
    output logic [MEM_DATA_WIDTH-1:0] d_membus_rdata_o,
    // shared memory port
    output logic                      membus_valid_o,
    input  logic                      membus_ready_i,
    output logic [MEM_ADDR_WIDTH-1:0] membus_addr_o,
    output logic                      membus_wen_o,
    output logic [MEM_DATA_WIDTH-1:0] membus_wdata_o,
    output logic [MEMBUS_WMASK_W-1:0] membus_wmask_o,
    input  logic                      membus_rvalid_i,
    input  logic [MEM_DATA_WIDTH-1:0] membus_rdata_i
);

    Owner     grant;
    Owner     lock_owner_q, lock_owner_d;
    Owner     head_owner;
    logic     lock_q, lock_d;
    logic     grant_valid;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_dout;
    logic     accept;
    logic     pop;
    MembusReq i_req;
    MembusReq d_req;
    MembusReq sel_req;

`ifdef MEMBUS_ARB_RR_EN
    Owner rr_last_q, rr_last_d;
`endif

    assign i_req = '{addr: i_membus_addr_i, wen: i_membus_wen_i,
                     wdata: i_membus_wdata_i, wmask: i_membus_wmask_i};
    assign d_req = '{addr: d_membus_addr_i, wen: d_membus_wen_i,
                     wdata: d_membus_wdata_i, wmask: d_membus_wmask_i};

    // A stalled request keeps the bus until its handshake so fields never switch mid-transfer.
    always_comb begin
        grant = OWNER_I;
        if (lock_q) begin
            grant = lock_owner_q;
        end
`ifdef MEMBUS_ARB_RR_EN
        else if (d_membus_valid_i && i_membus_valid_i) begin
            grant = other_owner(rr_last_q);
        end
`endif
        else if (d_membus_valid_i) begin
            grant = OWNER_D;
        end
    end

    assign sel_req     = (grant == OWNER_D) ? d_req : i_req;
    assign grant_valid = (grant == OWNER_D) ? d_membus_valid_i : i_membus_valid_i;

    assign membus_valid_o = !rst && grant_valid && !fifo_full;
    assign membus_addr_o  = sel_req.addr;
    assign membus_wen_o   = sel_req.wen;
    assign membus_wdata_o = sel_req.wdata;
    assign membus_wmask_o = sel_req.wmask;

    assign d_membus_ready_o = !rst && (grant == OWNER_D) && membus_ready_i && !fifo_full;
    assign i_membus_ready_o = !rst && (grant == OWNER_I) && membus_ready_i && !fifo_full;

    assign accept = membus_valid_o && membus_ready_i;

    // A response with nothing outstanding is dropped rather than forwarded.
    assign pop        = !rst && membus_rvalid_i && !fifo_empty;
    assign head_owner = Owner'(fifo_dout);

    assign d_membus_rvalid_o = pop && (head_owner == OWNER_D);
    assign i_membus_rvalid_o = pop && (head_owner == OWNER_I);
    assign d_membus_rdata_o  = membus_rdata_i;
    assign i_membus_rdata_o  = membus_rdata_i;

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (pop),
        .din_i   (grant == OWNER_D),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        lock_d       = membus_valid_o && !membus_ready_i;
        lock_owner_d = lock_owner_q;
        if (membus_valid_o && !membus_ready_i) begin
            lock_owner_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_I;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

`ifdef MEMBUS_ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (accept) begin
            rr_last_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= OWNER_I;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // The memory must never answer when no request is outstanding.
    assert property (@(posedge clk) disable iff (rst) !(membus_rvalid_i && fifo_empty));

endmodule
